// File: rtl/led_pattern_sequencer.sv
// led_pattern_sequencer: steps a 4-LED background pattern on a prescaled tick and lends the bank to one override requester
//  i_clk        system clock
//  i_rst        synchronous active-high reset
//  i_mode       background pattern select (0 shift-fill, 1 running light, 2 blink, 3 off)
//  i_mode_load  strobe: latch i_mode and restart the background pattern
//  i_ovr_req    override request level, held until o_ovr_ack
//  i_ovr_pat    override pattern, captured in the accept cycle
//  o_ovr_ack    one-cycle pulse after an override is accepted
//  o_ovr_busy   high while the override owns the LEDs
//  o_led        registered LED drive, 1 = on
module led_pattern_sequencer #(
  parameter int STEP_CYCLES = 25_000_000,
  parameter int OVR_STEPS   = 4,
  parameter int CNT_W       = 25
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [1:0] i_mode,
  input  logic       i_mode_load,
  input  logic       i_ovr_req,
  input  logic [3:0] i_ovr_pat,
  output logic       o_ovr_ack,
  output logic       o_ovr_busy,
  output logic [3:0] o_led
);
  localparam int SW = OVR_STEPS > 1 ? $clog2(OVR_STEPS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(STEP_CYCLES - 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(OVR_STEPS - 1);
  typedef enum logic {PATTERN, OVERRIDE} state_t;
  state_t r_state, w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [SW-1:0] r_steps;
  logic [1:0] r_mode;
  logic [3:0] r_bg, r_led, r_ovr, w_bg_init, w_bg_step, w_bg_next, w_led_next;
  logic r_ack, w_tick, w_accept, w_step, w_done;
  assign w_tick   = r_cnt == LAST_CNT;
  assign w_accept = r_state == PATTERN && i_ovr_req;
  // a tick landing on a prescaler clear (mode load or accept) is dropped
  assign w_step   = w_tick && !i_mode_load && !w_accept;
  assign w_done   = r_state == OVERRIDE && w_step && r_steps == LAST_STEP;
  always_ff @(posedge i_clk)
    if (i_rst) r_state <= PATTERN;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    if (w_accept) w_next = OVERRIDE;
    else if (w_done) w_next = PATTERN;
  end
  always_comb begin
    w_bg_init  = i_mode == 2'd1 ? 4'b0001 : i_mode == 2'd3 ? 4'b0000 : 4'b1111;
    w_bg_step  = r_mode == 2'd0 ? (r_bg == 4'b0000 ? 4'b1111 : {r_bg[2:0], 1'b0}) :
                 r_mode == 2'd1 ? {r_bg[2:0], r_bg[3]} :
                 r_mode == 2'd2 ? ~r_bg : 4'b0000;
    w_bg_next  = i_mode_load ? w_bg_init : (r_state == PATTERN && w_step) ? w_bg_step : r_bg;
    // the LED register follows the owner of the bank after this edge
    w_led_next = w_next == OVERRIDE ? (w_accept ? i_ovr_pat : r_ovr) : w_bg_next;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt   <= '0;
      r_mode  <= 2'd0;
      r_bg    <= 4'b1111;
      r_led   <= 4'b1111;
      r_ovr   <= 4'b0000;
      r_steps <= '0;
      r_ack   <= 1'b0;
    end else begin
      r_cnt <= (i_mode_load || w_accept || w_tick) ? '0 : r_cnt + CNT_W'(1);
      if (i_mode_load) r_mode <= i_mode;
      r_bg  <= w_bg_next;
      r_led <= w_led_next;
      r_ack <= w_accept;
      if (w_accept) begin
        r_ovr   <= i_ovr_pat;
        r_steps <= '0;
      end else if (r_state == OVERRIDE && w_step) r_steps <= r_steps + SW'(1);
    end
  end
  assign o_ovr_ack  = r_ack;
  assign o_ovr_busy = r_state == OVERRIDE;
  assign o_led      = r_led;
endmodule

// File: tb/tb_led_pattern_sequencer.sv
// tb_led_pattern_sequencer: directed scoreboard bench for led_pattern_sequencer (STEP_CYCLES=4, OVR_STEPS=2)
module tb_led_pattern_sequencer;
  logic clk = 1'b0, rst = 1'b1, mode_load = 1'b0, ovr_req = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [3:0] ovr_pat = 4'b0000;
  logic ovr_ack, ovr_busy;
  logic [3:0] led;
  int total = 0, bad = 0;
  typedef struct packed {logic [3:0] led; logic ack; logic busy;} exp_t;
  exp_t q[$];
  led_pattern_sequencer #(.STEP_CYCLES(4), .OVR_STEPS(2), .CNT_W(2)) dut (
    .i_clk(clk), .i_rst(rst), .i_mode(mode), .i_mode_load(mode_load),
    .i_ovr_req(ovr_req), .i_ovr_pat(ovr_pat), .o_ovr_ack(ovr_ack),
    .o_ovr_busy(ovr_busy), .o_led(led));
  always #5 clk = ~clk;
  task automatic cyc(input string tag, input logic [3:0] el, input logic ea, input logic eb);
    exp_t e;
    q.push_back('{led: el, ack: ea, busy: eb});
    @(posedge clk);
    #1;
    e = q.pop_front();
    total++;
    assert (led === e.led) else begin bad++; $error("FAIL %s led: got %b want %b", tag, led, e.led); end
    total++;
    assert (ovr_ack === e.ack) else begin bad++; $error("FAIL %s ack: got %b want %b", tag, ovr_ack, e.ack); end
    total++;
    assert (ovr_busy === e.busy) else begin bad++; $error("FAIL %s busy: got %b want %b", tag, ovr_busy, e.busy); end
  endtask
  task automatic hold(input string tag, input int n, input logic [3:0] el, input logic ea, input logic eb);
    for (int i = 0; i < n; i++) cyc(tag, el, ea, eb);
  endtask
  logic [3:0] fill[5] = '{4'b1110, 4'b1100, 4'b1000, 4'b0000, 4'b1111};
  logic [3:0] run[4] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
  initial begin
    #1;
    hold("reset", 3, 4'b1111, 1'b0, 1'b0);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      hold("fill_hold", 3, k == 0 ? 4'b1111 : fill[k-1], 1'b0, 1'b0);
      cyc("fill_step", fill[k], 1'b0, 1'b0);
    end
    mode = 2'd1; mode_load = 1'b1;
    cyc("run_load", 4'b0001, 1'b0, 1'b0);
    mode_load = 1'b0;
    for (int k = 0; k < 4; k++) begin
      hold("run_hold", 3, k == 0 ? 4'b0001 : run[k-1], 1'b0, 1'b0);
      cyc("run_step", run[k], 1'b0, 1'b0);
    end
    mode = 2'd2; mode_load = 1'b1;
    cyc("blink_load", 4'b1111, 1'b0, 1'b0);
    mode_load = 1'b0; ovr_req = 1'b1; ovr_pat = 4'b1010;
    cyc("ovr1_ack", 4'b1010, 1'b1, 1'b1);
    ovr_req = 1'b0;
    hold("ovr1_hold", 7, 4'b1010, 1'b0, 1'b1);
    cyc("ovr1_end", 4'b1111, 1'b0, 1'b0);
    hold("blink_frozen", 3, 4'b1111, 1'b0, 1'b0);
    cyc("blink_resume", 4'b0000, 1'b0, 1'b0);
    ovr_req = 1'b1; ovr_pat = 4'b1100;
    cyc("b2b_ack1", 4'b1100, 1'b1, 1'b1);
    ovr_pat = 4'b0101;
    hold("b2b_busy", 7, 4'b1100, 1'b0, 1'b1);
    cyc("b2b_gap", 4'b0000, 1'b0, 1'b0);
    cyc("b2b_ack2", 4'b0101, 1'b1, 1'b1);
    ovr_req = 1'b0;
    hold("b2b_hold2", 7, 4'b0101, 1'b0, 1'b1);
    cyc("b2b_end", 4'b0000, 1'b0, 1'b0);
    mode = 2'd3; mode_load = 1'b1; ovr_req = 1'b1; ovr_pat = 4'b0110;
    cyc("sim_ack", 4'b0110, 1'b1, 1'b1);
    mode_load = 1'b0; ovr_req = 1'b0;
    hold("sim_hold", 7, 4'b0110, 1'b0, 1'b1);
    cyc("sim_end", 4'b0000, 1'b0, 1'b0);
    hold("off_stay", 6, 4'b0000, 1'b0, 1'b0);
    ovr_req = 1'b1; ovr_pat = 4'b1001;
    cyc("rst_ovr_ack", 4'b1001, 1'b1, 1'b1);
    ovr_req = 1'b0;
    hold("rst_ovr_hold", 2, 4'b1001, 1'b0, 1'b1);
    rst = 1'b1; ovr_req = 1'b1; mode = 2'd1; mode_load = 1'b1;
    cyc("rst_mid", 4'b1111, 1'b0, 1'b0);
    rst = 1'b0; ovr_req = 1'b0; mode_load = 1'b0;
    hold("rst_after", 3, 4'b1111, 1'b0, 1'b0);
    cyc("rst_fill", 4'b1110, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
